// File: rtl/seq_det_pkg.sv
// seq_det_pkg: shared constants for the serial pattern detector controller.
//   WORD_W / CNT_W : job word width and per-job match counter width
//   PAT_W_DEF / PATTERN_DEF : default detected pattern (MSB received first)
//   ST_* : controller FSM state encoding
package seq_det_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned CNT_W     = 6;
  localparam int unsigned BIT_IDX_W = 5;

  localparam int unsigned          PAT_W_DEF   = 7;
  localparam logic [PAT_W_DEF-1:0] PATTERN_DEF = 7'b1011001;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_FLUSH  = 2'd2;
  localparam logic [1:0] ST_REPORT = 2'd3;

endpackage

// File: rtl/seq_det.sv
// seq_det: overlapping serial pattern detector with a registered match pulse.
//   clk, rst : clock, async active-high reset
//   clr      : synchronous clear of history (job start)
//   i_val    : serial input bit, one per clock
//   o_match  : one-cycle pulse the cycle after the bit completing PATTERN
module seq_det
  import seq_det_pkg::*;
#(
  parameter int unsigned      PAT_W   = PAT_W_DEF,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(PATTERN_DEF)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic i_val,
  output logic o_match
);

  localparam int unsigned FILL_W = $clog2(PAT_W + 1);

  logic [PAT_W-2:0]  r_sh;
  logic [FILL_W-1:0] r_fill;
  logic              r_match;
  logic [PAT_W-1:0]  w_window;
  logic              w_full;

  assign w_window = {r_sh, i_val};
  // Window only counts once PAT_W real bits arrived since clr, so cleared
  // history can never complete a pattern that starts with zeros.
  assign w_full   = (r_fill >= FILL_W'(PAT_W - 1));
  assign o_match  = r_match;

  // History shift register, fill tracker and registered compare
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh    <= '0;
      r_fill  <= '0;
      r_match <= 1'b0;
    end else if (clr) begin
      r_sh    <= '0;
      r_fill  <= '0;
      r_match <= 1'b0;
    end else begin
      r_sh    <= w_window[PAT_W-2:0];
      r_match <= w_full && (w_window == PATTERN);
      if (r_fill != FILL_W'(PAT_W)) begin
        r_fill <= r_fill + FILL_W'(1);
      end
    end
  end

endmodule

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: two-requester round-robin job controller. A granted word is
// serialized MSB first into seq_det and the matches are counted per job.
//   clk, rst        : clock, async active-high reset
//   req[1:0]        : request level per requester
//   word0, word1    : job words, sampled only at grant
//   ack[1:0]        : one-cycle grant pulse
//   busy            : grant cycle through done cycle
//   ser_bit         : bit currently fed to the detector (0 outside SHIFT)
//   done            : one-cycle job-complete pulse
//   done_id         : requester of completed job (held)
//   match_cnt       : detections in completed job (held)
module seq_det_ctrl
  import seq_det_pkg::*;
#(
  parameter int unsigned      PAT_W   = PAT_W_DEF,
  parameter logic [PAT_W-1:0] PATTERN = PAT_W'(PATTERN_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [WORD_W-1:0] word0,
  input  logic [WORD_W-1:0] word1,
  output logic [1:0]        ack,
  output logic              busy,
  output logic              ser_bit,
  output logic              done,
  output logic              done_id,
  output logic [CNT_W-1:0]  match_cnt
);

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic                 w_grant;
  logic                 w_win_id;
  logic [WORD_W-1:0]    w_win_word;
  logic                 w_last_bit;
  logic                 w_match;

  logic                 r_last;
  logic                 r_id;
  logic [WORD_W-1:0]    r_shreg;
  logic [BIT_IDX_W-1:0] r_bit_idx;
  logic [CNT_W-1:0]     r_cnt;
  logic [1:0]           r_ack;
  logic                 r_busy;
  logic                 r_ser_bit;
  logic                 r_done;
  logic                 r_done_id;
  logic [CNT_W-1:0]     r_match_cnt;

  assign w_last_bit = (r_bit_idx == BIT_IDX_W'(WORD_W - 1));
  assign w_win_word = w_win_id ? word1 : word0;

  assign ack       = r_ack;
  assign busy      = r_busy;
  assign ser_bit   = r_ser_bit;
  assign done      = r_done;
  assign done_id   = r_done_id;
  assign match_cnt = r_match_cnt;

  // Next-state and round-robin arbitration
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_win_id    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (req != 2'b00) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_SHIFT;
          // On contention the requester not served last wins
          w_win_id    = (req == 2'b11) ? ~r_last : req[1];
        end
      end
      ST_SHIFT: begin
        if (w_last_bit) begin
          w_state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH:  w_state_nxt = ST_REPORT;
      ST_REPORT: w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Capture, serializer, match counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last      <= 1'b1;  // requester 0 favoured after reset
      r_id        <= 1'b0;
      r_shreg     <= '0;
      r_bit_idx   <= '0;
      r_cnt       <= '0;
      r_ack       <= 2'b00;
      r_busy      <= 1'b0;
      r_ser_bit   <= 1'b0;
      r_done      <= 1'b0;
      r_done_id   <= 1'b0;
      r_match_cnt <= '0;
    end else begin
      r_ack     <= 2'b00;
      r_done    <= 1'b0;
      r_ser_bit <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant) begin
            r_ack     <= w_win_id ? 2'b10 : 2'b01;
            r_busy    <= 1'b1;
            r_id      <= w_win_id;
            r_last    <= w_win_id;
            r_ser_bit <= w_win_word[WORD_W-1];
            r_shreg   <= {w_win_word[WORD_W-2:0], 1'b0};
            r_bit_idx <= '0;
            r_cnt     <= '0;
          end
        end
        ST_SHIFT: begin
          if (w_match) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
          if (!w_last_bit) begin
            r_ser_bit <= r_shreg[WORD_W-1];
            r_shreg   <= {r_shreg[WORD_W-2:0], 1'b0};
            r_bit_idx <= r_bit_idx + BIT_IDX_W'(1);
          end
        end
        ST_FLUSH: begin
          // Match pulse for bit 31 lands here; fold it into the result
          r_done      <= 1'b1;
          r_done_id   <= r_id;
          r_match_cnt <= r_cnt + CNT_W'(w_match);
        end
        ST_REPORT: begin
          r_busy <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  seq_det #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN)
  ) u_seq_det (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_grant),
    .i_val   (r_ser_bit),
    .o_match (w_match)
  );

endmodule
